// File: rtl/fadd_wb_ctrl.sv
// Issue/writeback control for the 3-stage pipelined FP adder: destination-tag tracking, result writeback, RAW stalls.
// Latency: issue to wb_valid is exactly 3 e=1 edges; iss_ack/stall/busy are combinational.
// Backpressure: e=0 freezes the A/C tags and wb_rd/wb_data (wb_valid drops); a RAW hit raises stall and withholds iss_ack.
//
// Ports:
//   clk, clrn          rising-edge clock, asynchronous active-low reset
//   e, flush           pipeline advance enable (shared with the adder), kill of stages A and C
//   iss_valid, iss_rd, iss_fs, iss_ft   issuing add/sub and its register numbers
//   s                  adder result from its normalization stage
//   iss_ack, stall     issue accepted / RAW hazard against in-flight work
//   wb_valid, wb_rd, wb_data            one-cycle register-file write
//   busy, retired      any stage valid / count of completed writebacks
module fadd_wb_ctrl (
   input  logic        clk,
   input  logic        clrn,
   input  logic        e,
   input  logic        flush,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  iss_fs,
   input  logic [4:0]  iss_ft,
   input  logic [31:0] s,
   output logic        iss_ack,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic [15:0] retired
);

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
   } tag_t;

   tag_t        a_q, a_d;         // aligned with the adder's align/cal register
   tag_t        c_q, c_d;         // aligned with the adder's cal/norm register
   logic        wb_vld_q, wb_vld_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [15:0] retired_q, retired_d;

   function automatic logic src_hit(input logic vld, input logic [4:0] rd,
                                    input logic [4:0] fs, input logic [4:0] ft);
      return vld && ((fs == rd) || (ft == rd));
   endfunction

   // Register 0 is treated like any other FP register.
   always_comb begin
      stall   = iss_valid && (src_hit(a_q.vld, a_q.rd, iss_fs, iss_ft) ||
                              src_hit(c_q.vld, c_q.rd, iss_fs, iss_ft) ||
                              src_hit(wb_vld_q, wb_rd_q, iss_fs, iss_ft));
      iss_ack = iss_valid && !stall && e && !flush;
      busy    = a_q.vld || c_q.vld || wb_vld_q;
   end

   always_comb begin
      a_d       = a_q;
      c_d       = c_q;
      wb_vld_d  = 1'b0;           // a stalled edge never repeats a write
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      retired_d = retired_q;
      if (e) begin
         a_d.vld   = iss_ack;
         a_d.rd    = iss_rd;
         c_d       = a_q;
         wb_vld_d  = c_q.vld;
         wb_rd_d   = c_q.rd;
         // Data is captured even for a bubble; wb_valid alone qualifies it.
         wb_data_d = s;
      end
      // WB above already took the pre-flush C, so the op leaving C still retires.
      if (flush) begin
         a_d.vld = 1'b0;
         c_d.vld = 1'b0;
      end
      if (wb_vld_d) begin
         retired_d = retired_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         a_q       <= '0;
         c_q       <= '0;
         wb_vld_q  <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         retired_q <= '0;
      end else begin
         a_q       <= a_d;
         c_q       <= c_d;
         wb_vld_q  <= wb_vld_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         retired_q <= retired_d;
      end
   end

   assign wb_valid = wb_vld_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_fadd_wb_ctrl.sv
// Testbench for fadd_wb_ctrl: directed issue sequences with a queue-based writeback scoreboard.
// The adder result s is a known function of the count of e=1 edges, so expected writeback data is
// f(issue_edge + 2) and the writeback must appear while the edge count equals issue_edge + 3.
module tb_fadd_wb_ctrl;

   logic        clk = 1'b0;
   logic        clrn;
   logic        e;
   logic        flush;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  iss_fs;
   logic [4:0]  iss_ft;
   logic [31:0] s;
   logic        iss_ack;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        busy;
   logic [15:0] retired;

   fadd_wb_ctrl dut (
      .clk(clk), .clrn(clrn), .e(e), .flush(flush),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_fs(iss_fs), .iss_ft(iss_ft),
      .s(s), .iss_ack(iss_ack), .stall(stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy(busy), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rd;
      int         idx;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          ecnt   = 0;       // number of e=1 edges seen out of reset
   logic [15:0] exp_ret = '0;

   function automatic logic [31:0] f(input int n);
      logic [31:0] nn;
      nn = n;
      return 32'h3F80_0000 ^ (nn * 32'h0001_9E37);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(posedge clk) if (clrn && e) ecnt++;
   always @(negedge clk) s = f(ecnt);

   // Scoreboard monitor: every wb_valid cycle must match the oldest expected writeback.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (clrn && wb_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_wb", {27'd0, wb_rd}, 32'hFFFF_FFFF);
            end else begin
               x = exp_q.pop_front();
               chk("wb_rd", {27'd0, wb_rd}, {27'd0, x.rd});
               chk("wb_data", wb_data, f(x.idx + 2));
               chk("wb_time", ecnt, x.idx + 3);
            end
         end
      end
   end

   // One cycle: drive at posedge+1, check ack/stall at negedge, return at next posedge+1.
   task automatic step(input logic v, input logic [4:0] rd, input logic [4:0] fs,
                       input logic [4:0] ft, input logic en, input logic fl,
                       input logic x_ack, input logic x_stall, input logic push);
      exp_t x;
      iss_valid = v; iss_rd = rd; iss_fs = fs; iss_ft = ft; e = en; flush = fl;
      @(negedge clk);
      chk("iss_ack", {31'd0, iss_ack}, {31'd0, x_ack});
      chk("stall", {31'd0, stall}, {31'd0, x_stall});
      if (push) begin
         x.rd = rd;
         x.idx = ecnt;
         exp_q.push_back(x);
         exp_ret = exp_ret + 16'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset pulse between edges; outputs must clear without a clock edge.
   task automatic pulse_reset();
      clrn = 1'b0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_retired", {16'd0, retired}, 32'd0);
      exp_q.delete();
      exp_ret = '0;
      #1;
      clrn = 1'b1;
   endtask

   initial begin
      clrn = 1'b0; e = 1'b0; flush = 1'b0; iss_valid = 1'b0;
      iss_rd = '0; iss_fs = '0; iss_ft = '0; s = f(0);
      #2;
      chk("init_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("init_busy", {31'd0, busy}, 32'd0);
      chk("init_wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("init_wb_data", wb_data, 32'd0);
      chk("init_retired", {16'd0, retired}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      clrn = 1'b1;

      // Single issue rd=3.
      step(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("busy_in_flight", {31'd0, busy}, 32'd1);
      idle(4);
      chk("retired_single", {16'd0, retired}, {16'd0, exp_ret});
      chk("busy_drained", {31'd0, busy}, 32'd0);
      // Bubble edge still captures s.
      chk("wb_data_bubble", wb_data, f(ecnt - 1));

      // RAW on rd=5: three stalled cycles, accepted on the fourth.
      step(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 5'd9, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 5'd9, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(4);

      // Register 0 hazard via ft.
      step(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 5'd4, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);

      // e=0 for two cycles after issue; writeback then held off by another e=0 cycle.
      step(1'b1, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("busy_frozen", {31'd0, busy}, 32'd1);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("wb_rd_held", {27'd0, wb_rd}, 32'd6);
      idle(2);

      // Flush: rd=7 leaves C on the flush edge and retires, rd=8 is killed; same-cycle issue dropped.
      step(1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 5'd8, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      chk("retired_flush", {16'd0, retired}, {16'd0, exp_ret});

      // Three tags in flight, reset pulse kills them all.
      step(1'b1, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd12, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("busy_before_rst", {31'd0, busy}, 32'd1);
      pulse_reset();
      idle(5);
      chk("retired_after_rst", {16'd0, retired}, 32'd0);

      // Counter wrap: 0xFFFF writebacks, then one more.
      for (int i = 0; i < 65535; i++) begin
         step(1'b1, 5'(1 + (i % 31)), 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      idle(4);
      chk("retired_ffff", {16'd0, retired}, 32'h0000_FFFF);
      step(1'b1, 5'd20, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(4);
      chk("retired_wrap", {16'd0, retired}, 32'h0000_0000);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fadd_wb_ctrl.md
FADD_WB_CTRL -- requirements
Module: fadd_wb_ctrl

Purpose: issue/writeback control wrapped around the 3-stage pipelined FP adder. Tracks destination tags in lockstep with the adder's two pipeline registers, registers the adder result for FP register-file writeback, and raises RAW-hazard stalls.

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk and clrn.
REQ-002 clk  input  1  rising-edge clock shared with the adder.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 e  input  1  pipeline advance enable, the same signal driving the adder's e.
REQ-005 flush  input  1  synchronous kill of in-flight stages A and C.
REQ-006 iss_valid  input  1  an add/sub is presented for issue this cycle.
REQ-007 iss_rd  input  5  destination FP register of the issuing operation.
REQ-008 iss_fs, iss_ft  input  5 each  source FP registers of the issuing operation.
REQ-009 s  input  32  adder result, combinational from the adder's normalization stage.
REQ-010 iss_ack  output  1  issue accepted this cycle.
REQ-011 stall  output  1  RAW hazard against in-flight work.
REQ-012 wb_valid  output  1  one-cycle register-file write strobe.
REQ-013 wb_rd  output  5  writeback destination register.
REQ-014 wb_data  output  32  writeback value.
REQ-015 busy  output  1  any of stages A, C or WB holds a valid tag.
REQ-016 retired  output  16  count of completed writebacks.

Function
REQ-017 The block SHALL hold three tag registers, each made of a valid bit and a 5-bit rd: A (aligned with the adder's align/cal register), C (aligned with its cal/norm register) and WB.
REQ-018 The block SHALL drive stall = iss_valid and (iss_fs or iss_ft equals rd of any valid A, C or WB tag); register 0 SHALL get no special treatment.
REQ-019 The block SHALL drive iss_ack = iss_valid and not stall and e and not flush, combinationally.
REQ-020 On a rising edge with e=1: A.valid SHALL load iss_ack and A.rd SHALL load iss_rd; C SHALL load A; WB SHALL load C; wb_data SHALL load s.
REQ-021 When C.valid=0, the e=1 edge SHALL still load wb_data with s; only wb_valid gates use of the data.
REQ-022 On a rising edge with e=0: A, C, wb_rd and wb_data SHALL hold, and wb_valid SHALL clear to 0 so that a write is never repeated.
REQ-023 Issue-to-writeback latency SHALL be exactly 3 e=1 edges; wb_valid SHALL be high for exactly one cycle per accepted issue.
REQ-024 flush=1 at an edge SHALL clear A.valid and C.valid regardless of e. WB SHALL still update per REQ-020/022 using the pre-flush C.
REQ-025 Issue and flush in the same cycle: flush SHALL win and the issue SHALL be dropped (iss_ack=0).
REQ-026 retired SHALL increment on every edge at which wb_valid transitions to 1, wrapping from 0xFFFF to 0x0000.
REQ-027 The block SHALL drive busy = A.valid or C.valid or wb_valid, combinationally.
REQ-028 Back-to-back independent issues SHALL be accepted every e=1 cycle, giving a throughput of 1 per cycle.

Reset
REQ-029 With clrn=0, the block SHALL asynchronously clear A.valid, C.valid and wb_valid to 0, wb_rd to 0, wb_data to 0x00000000 and retired to 0, independent of clk and e.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight tags; the first edge after release SHALL behave as an edge from the empty state.

Verification
REQ-031 Single issue rd=3, e=1 held -> iss_ack=1 in cycle 0, wb_valid=1 in cycle 3 only, wb_rd=3, wb_data equals s sampled at edge 3, retired=1.
REQ-032 Issue rd=5, then next cycle iss_fs=5 -> stall=1 and iss_ack=0 for 3 cycles; iss_ack=1 on the cycle after WB retires rd 5.
REQ-033 Issue, then e=0 for 2 cycles starting at cycle 1 -> tags frozen, wb_valid asserts at cycle 5 for exactly one cycle.
REQ-034 Issue rd=7 and rd=8 back-to-back, then flush in cycle 2 -> rd=7 still writes back (it is in C, so WB captures it before the flush takes effect), rd=8 is killed, retired=1.
REQ-035 Start from retired=0xFFFF, then one writeback -> retired=0x0000.
REQ-036 Pulse clrn low between edges with 3 tags in flight -> all valids and busy go to 0 immediately, and no wb_valid follows.
